// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for a shared combinational ALU: 1-cycle EXEC (MULDIV_CYCLES for MUL/DIV), response held until resp_ready.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default build is fixed priority (requester 0 wins).
module alu_arbiter #(
  parameter int MULDIV_CYCLES = 4,
  parameter int WIDTH         = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [11:0]        req_func,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [5:0]         alu_func,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_out,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_data,
  output logic               resp_err,
  output logic               busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [5:0] FUNC_MUL  = 6'd2;
  localparam logic [5:0] FUNC_DIV  = 6'd3;
  localparam logic [5:0] FUNC_LAST = 6'd5;
  localparam logic [3:0] CNT_LOAD  = 4'(MULDIV_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [5:0]       func_q, func_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic             last_q, last_d;
`endif

  logic             gnt_vld;
  logic             gnt_id;
  logic [5:0]       sel_func;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == S_IDLE) begin
      case (req_valid)
        2'b01: begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end
        2'b10: begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
        2'b11: begin
          gnt_vld = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          gnt_id  = ~last_q;
`else
          gnt_id  = 1'b0;
`endif
        end
        default: begin
          gnt_vld = 1'b0;
          gnt_id  = 1'b0;
        end
      endcase
    end
  end

  assign req_ready = gnt_vld ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign sel_func  = gnt_id ? req_func[11:6] : req_func[5:0];
  assign sel_a     = gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign sel_b     = gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    func_d      = func_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          func_d  = sel_func;
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = gnt_id;
          cnt_d   = (sel_func == FUNC_MUL || sel_func == FUNC_DIV) ? CNT_LOAD : 4'd0;
          state_d = S_EXEC;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = gnt_id;
`endif
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_id_d = id_q;
          state_d   = S_RESP;
          // Error results override whatever the ALU produced.
          if (func_q > FUNC_LAST) begin
            resp_err_d  = 1'b1;
            resp_data_d = '0;
          end else if (func_q == FUNC_DIV && b_q == '0) begin
            resp_err_d  = 1'b1;
            resp_data_d = '1;
          end else begin
            resp_err_d  = 1'b0;
            resp_data_d = alu_out;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      func_q      <= 6'd0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      resp_id_q   <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      func_q      <= func_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  // Operands reach the ALU only while executing so it sees zeros when idle.
  assign alu_func   = (state_q == S_EXEC) ? func_q : 6'd0;
  assign alu_a      = (state_q == S_EXEC) ? a_q : '0;
  assign alu_b      = (state_q == S_EXEC) ? b_q : '0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: randomized and directed ops, with a timestamp-based reference model.
module tb_alu_arbiter;
  localparam int MDC = 4;

  typedef struct packed {
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [11:0] req_func;
  logic [63:0] req_a, req_b;
  logic [5:0]  alu_func;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  alu_arbiter #(.MULDIV_CYCLES(MDC), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_a(req_a), .req_b(req_b),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  // Shared ALU stand-in; div-by-zero and undefined funcs return junk the arbiter must discard.
  function automatic logic [31:0] alu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a * b;
      6'd3:    return (b == 32'd0) ? 32'h1234_5678 : a / b;
      6'd4:    return a & b;
      6'd5:    return a | b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_func, alu_a, alu_b);

  function automatic rsp_t expect_rsp(input logic id, input op_t op);
    rsp_t r;
    r.id   = id;
    r.err  = 1'b0;
    r.data = alu_ref(op.func, op.a, op.b);
    if (op.func > 6'd5) begin
      r.err  = 1'b1;
      r.data = 32'd0;
    end else if (op.func == 6'd3 && op.b == 32'd0) begin
      r.err  = 1'b1;
      r.data = 32'hFFFF_FFFF;
    end
    return r;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Requester drivers: each holds valid and operands until its req_ready.
  op_t        cur0, cur1;
  op_t        opq0[$], opq1[$];
  logic [1:0] v;
  logic [1:0] acc;
  logic       gap_en;

  assign req_valid = v;
  assign req_func  = {cur1.func, cur0.func};
  assign req_a     = {cur1.a, cur0.a};
  assign req_b     = {cur1.b, cur0.b};

  initial begin
    v    = 2'b00;
    cur0 = '0;
    cur1 = '0;
    forever begin
      @(negedge clk);
      acc = req_ready & v;
      @(posedge clk);
      #1;
      if (acc[0]) v[0] = 1'b0;
      if (acc[1]) v[1] = 1'b0;
      if (!v[0] && opq0.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        cur0 = opq0.pop_front();
        v[0] = 1'b1;
      end
      if (!v[1] && opq1.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        cur1 = opq1.pop_front();
        v[1] = 1'b1;
      end
    end
  end

  // Reference model: tracks grant time and latency of the one outstanding op.
  int   cyc = 0;
  logic rst_edge = 1'b0;
  logic mon_en = 1'b0;
  logic m_out = 1'b0;
  logic m_exec = 1'b0;
  int   m_gnt_cyc = 0;
  int   m_lat = 1;
  op_t  m_op;
  int   ex_cnt = 0;
`ifdef ARB_ROUND_ROBIN_EN
  logic m_last = 1'b1;
`endif
  rsp_t sb[$];
  rsp_t got_log[$];

  always @(posedge clk) begin
    cyc      = cyc + 1;
    rst_edge = !rst_n;
  end

  always @(negedge clk) begin
    logic       in_flight, rv_exp, ex, win_vld, win_id;
    logic [1:0] exp_rdy;
    op_t        wop;
    if (rst_edge) begin
      mon_en = 1'b1;
      m_out  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last = 1'b1;
`endif
      sb.delete();
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
    end
    if (mon_en) begin
      in_flight = m_out && (cyc > m_gnt_cyc);
      rv_exp    = in_flight && (cyc >= m_gnt_cyc + 1 + m_lat);
      ex        = in_flight && !rv_exp;
      m_exec    = ex;
      if (busy && !resp_valid) ex_cnt++;
      win_vld = 1'b0;
      win_id  = 1'b0;
      if (!m_out && req_valid != 2'b00) begin
        win_vld = 1'b1;
        if (req_valid == 2'b10) win_id = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        else if (req_valid == 2'b11) win_id = !m_last;
`endif
      end
      exp_rdy = win_vld ? (win_id ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(in_flight));
      chk("resp_valid", 32'(resp_valid), 32'(rv_exp));
      chk("alu_func", 32'(alu_func), ex ? 32'(m_op.func) : 32'd0);
      chk("alu_a", alu_a, ex ? m_op.a : 32'd0);
      chk("alu_b", alu_b, ex ? m_op.b : 32'd0);
      if (rv_exp) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          chk("resp_id", 32'(resp_id), 32'(sb[0].id));
          chk("resp_data", resp_data, sb[0].data);
          chk("resp_err", 32'(resp_err), 32'(sb[0].err));
          if (resp_ready) begin
            void'(sb.pop_front());
            got_log.push_back('{resp_id, resp_data, resp_err});
            m_out = 1'b0;
          end
        end
      end
      if (win_vld && rst_n) begin
        wop       = win_id ? cur1 : cur0;
        m_out     = 1'b1;
        m_gnt_cyc = cyc;
        m_op      = wop;
        m_lat     = (wop.func == 6'd2 || wop.func == 6'd3) ? MDC : 1;
`ifdef ARB_ROUND_ROBIN_EN
        m_last    = win_id;
`endif
        sb.push_back(expect_rsp(win_id, wop));
      end
    end
  end

  task automatic wait_idle(input int budget, input logic rand_rdy);
    int n;
    n = 0;
    while ((opq0.size() != 0 || opq1.size() != 0 || v != 2'b00 || m_out) && n < budget) begin
      @(posedge clk);
      #1;
      if (rand_rdy) resp_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   base;
    int   n;
    int   exp_ord[6];
    int   e0;
    op_t  op;
    rst_n      = 1'b0;
    resp_ready = 1'b0;
    gap_en     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_alu_func", 32'(alu_func), 32'd0);

    // ADD from requester 0
    @(posedge clk);
    #1 resp_ready = 1'b1;
    base = got_log.size();
    opq0.push_back('{6'd0, 32'd5, 32'd7});
    wait_idle(100, 1'b0);
    chk("add_count", got_log.size(), base + 1);
    chk("add_data", got_log[base].data, 32'd12);
    chk("add_id", 32'(got_log[base].id), 32'd0);
    chk("add_err", 32'(got_log[base].err), 32'd0);

    // MUL from requester 1 holds operands for MDC cycles
    base = got_log.size();
    e0   = ex_cnt;
    opq1.push_back('{6'd2, 32'd6, 32'd7});
    wait_idle(100, 1'b0);
    chk("mul_exec_cycles", ex_cnt - e0, MDC);
    chk("mul_data", got_log[base].data, 32'd42);
    chk("mul_id", 32'(got_log[base].id), 32'd1);

    // Simultaneous requests, three ops each
    base = got_log.size();
    for (int i = 0; i < 3; i++) begin
      opq0.push_back('{6'd0, 32'(i), 32'd100});
      opq1.push_back('{6'd4, 32'hFF, 32'(i + 16)});
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_ord = '{0, 1, 0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 1, 1, 1};
`endif
    wait_idle(200, 1'b0);
    chk("tie_count", got_log.size(), base + 6);
    for (int i = 0; i < 6; i++) chk("tie_order", 32'(got_log[base + i].id), 32'(exp_ord[i]));

    // Divide by zero, then undefined func
    base = got_log.size();
    opq0.push_back('{6'd3, 32'd100, 32'd0});
    wait_idle(100, 1'b0);
    opq1.push_back('{6'd7, 32'd1, 32'd2});
    wait_idle(100, 1'b0);
    chk("div0_data", got_log[base].data, 32'hFFFF_FFFF);
    chk("div0_err", 32'(got_log[base].err), 32'd1);
    chk("illegal_data", got_log[base + 1].data, 32'd0);
    chk("illegal_err", 32'(got_log[base + 1].err), 32'd1);

    // Backpressure with a second request pending
    resp_ready = 1'b0;
    base = got_log.size();
    opq0.push_back('{6'd0, 32'd1, 32'd2});
    opq0.push_back('{6'd0, 32'd3, 32'd4});
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_resp", 32'(n < 50), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(resp_valid), 32'd1);
      chk("bp_data_held", resp_data, 32'd3);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_idle(100, 1'b0);
    chk("bp_count", got_log.size(), base + 2);
    chk("bp_second", got_log[base + 1].data, 32'd7);

    // Reset during a DIV in EXEC drops it silently
    base = got_log.size();
    opq0.push_back('{6'd3, 32'd100, 32'd5});
    n = 0;
    while (!m_exec && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_reach_exec", 32'(n < 50), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (10) @(posedge clk);
    chk("abort_no_resp", got_log.size(), base);

    // Randomized traffic with random backpressure and gaps
    gap_en = 1'b1;
    base   = got_log.size();
    for (int i = 0; i < 300; i++) begin
      op.func = 6'($urandom_range(0, 11));
      if (op.func >= 6'd8) op.func = ($urandom_range(0, 1) != 0) ? 6'd2 : 6'd3;
      else if (op.func == 6'd7) op.func = 6'($urandom_range(6, 63));
      op.a = $urandom;
      op.b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) != 0) opq0.push_back(op);
      else opq1.push_back(op);
    end
    wait_idle(20000, 1'b1);
    chk("random_count", got_log.size(), base + 300);
    gap_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
